// File: rtl/multi_feynman_pipe.sv
// multi_feynman_pipe
//   Two-stage valid/ready pipeline implementing a multi-target Feynman (CNOT)
//   gate: the control line a is passed through as p, and each enabled target
//   line b_i is XORed with a to form q_i. Each bit position is an independent
//   gate lane.
//
// Parameters
//   WIDTH   : bits per line
//   TARGETS : number of target lines (1..16)
//   CNT_W   : width of the saturating completed-transaction counter
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : input transaction present
//   in_ready  : block accepts input this cycle
//   a         : control line
//   b         : target lines, target i in b[i*WIDTH +: WIDTH]
//   tmask     : per-transaction target enable
//   out_valid : output transaction present
//   out_ready : downstream accepts output
//   p         : pass-through control line
//   q         : target results, same packing as b
//   par_ok    : XOR of all p/q bits equals XOR of all a/b bits
//   txn_cnt   : number of completed output transfers (saturating)
module multi_feynman_pipe #(
  parameter int WIDTH   = 1,
  parameter int TARGETS = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [TARGETS*WIDTH-1:0]   b,
  input  logic [TARGETS-1:0]         tmask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           p,
  output logic [TARGETS*WIDTH-1:0]   q,
  output logic                       par_ok,
  output logic [CNT_W-1:0]           txn_cnt
);

  // Stage 1 registers
  logic                     s1_valid;
  logic [WIDTH-1:0]         s1_a;
  logic [TARGETS*WIDTH-1:0] s1_b;
  logic [TARGETS-1:0]       s1_mask;

  // Stage 2 valid (data registers are the p/q/par_ok outputs)
  logic                     s2_valid;

  logic                     stall;
  logic [TARGETS*WIDTH-1:0] q_next;
  logic                     par_next;

  // A full, unaccepted output freezes the whole pipe; bubbles are not collapsed.
  assign stall     = s2_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = s2_valid;

  always_comb begin
    q_next = s1_b;
    for (int unsigned i = 0; i < TARGETS; i++) begin
      if (s1_mask[i]) begin
        q_next[i*WIDTH +: WIDTH] = s1_b[i*WIDTH +: WIDTH] ^ s1_a;
      end
    end
    // Parity of the result (p = a plus q) against parity of the operands.
    par_next = ((^s1_a) ^ (^q_next)) == ((^s1_a) ^ (^s1_b));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mask  <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_mask <= tmask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      p        <= '0;
      q        <= '0;
      par_ok   <= 1'b1;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        p      <= s1_a;
        q      <= q_next;
        par_ok <= par_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt <= '0;
    end else if (s2_valid && out_ready && (txn_cnt != '1)) begin
      txn_cnt <= txn_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_feynman_pipe.sv
// Directed self-checking bench for multi_feynman_pipe. Three instances:
//   x : WIDTH=1, TARGETS=2, CNT_W=16 (double Feynman gate, streaming, reset)
//   w : WIDTH=4, TARGETS=3, CNT_W=16 (wide lanes, self-inverse)
//   s : WIDTH=1, TARGETS=2, CNT_W=3  (counter saturation)
module tb_multi_feynman_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // instance x
  logic        x_in_valid, x_in_ready, x_a, x_out_valid, x_out_ready, x_p, x_par_ok;
  logic [1:0]  x_b, x_tmask, x_q;
  logic [15:0] x_cnt;
  // instance w
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_par_ok;
  logic [3:0]  w_a, w_p;
  logic [11:0] w_b, w_q;
  logic [2:0]  w_tmask;
  logic [15:0] w_cnt;
  // instance s
  logic        s_in_valid, s_in_ready, s_a, s_out_valid, s_out_ready, s_p, s_par_ok;
  logic [1:0]  s_b, s_tmask, s_q;
  logic [2:0]  s_cnt;

  multi_feynman_pipe #(.WIDTH(1), .TARGETS(2), .CNT_W(16)) dut_x (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .a(x_a), .b(x_b), .tmask(x_tmask), .out_valid(x_out_valid),
    .out_ready(x_out_ready), .p(x_p), .q(x_q), .par_ok(x_par_ok), .txn_cnt(x_cnt));

  multi_feynman_pipe #(.WIDTH(4), .TARGETS(3), .CNT_W(16)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .tmask(w_tmask), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .p(w_p), .q(w_q), .par_ok(w_par_ok), .txn_cnt(w_cnt));

  multi_feynman_pipe #(.WIDTH(1), .TARGETS(2), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .tmask(s_tmask), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .p(s_p), .q(s_q), .par_ok(s_par_ok), .txn_cnt(s_cnt));

  task automatic do_reset();
    x_in_valid = 0; x_a = 0; x_b = 0; x_tmask = 0; x_out_ready = 1;
    w_in_valid = 0; w_a = 0; w_b = 0; w_tmask = 0; w_out_ready = 1;
    s_in_valid = 0; s_a = 0; s_b = 0; s_tmask = 0; s_out_ready = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    x_in_valid = 0; x_out_ready = 1; w_in_valid = 0; w_out_ready = 1;
    s_in_valid = 0; s_out_ready = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (x_out_valid !== 1'b0 || x_p !== 1'b0 || x_q !== 2'b00 || x_par_ok !== 1'b1 || x_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: got ov=%b p=%b q=%b par=%b cnt=%0d exp ov=0 p=0 q=00 par=1 cnt=0",
               x_out_valid, x_p, x_q, x_par_ok, x_cnt);
    end
    rst = 0;
    @(posedge clk); #1;
    checks++;
    if (x_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b exp 1", x_in_ready);
    end
  endtask

  task automatic send_x(input logic av, input logic [1:0] bv, input logic [1:0] mv,
                        input logic ep, input logic [1:0] eq, input logic epar, input string nm);
    x_a = av; x_b = bv; x_tmask = mv; x_in_valid = 1;
    @(posedge clk); #1;
    x_in_valid = 0;
    checks++;
    if (x_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_latency1: out_valid got %b exp 0", nm, x_out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (x_out_valid !== 1'b1 || x_p !== ep || x_q !== eq || x_par_ok !== epar) begin
      failures++;
      $display("FAIL %s: got ov=%b p=%b q=%b par=%b exp ov=1 p=%b q=%b par=%b",
               nm, x_out_valid, x_p, x_q, x_par_ok, ep, eq, epar);
    end
  endtask

  task automatic test_exhaustive();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic av;
      logic [1:0] bv;
      av = i[2];
      bv = i[1:0];
      send_x(av, bv, 2'b11, av, {av ^ bv[1], av ^ bv[0]}, 1'b1, $sformatf("exh%0d", i));
    end
    // single target, a=1: parity flips
    send_x(1'b1, 2'b00, 2'b01, 1'b1, 2'b01, 1'b0, "par_flip");
    // no targets enabled: q = b, still counted
    send_x(1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, "mask_zero");
    @(posedge clk); #1;
    checks++;
    if (x_cnt !== 16'd10) begin
      failures++;
      $display("FAIL exh_count: got %0d exp 10", x_cnt);
    end
  endtask

  task automatic run_w(input logic [3:0] av, input logic [11:0] bv, input logic [2:0] mv,
                       input logic [3:0] ep, input logic [11:0] eq, input logic epar, input string nm);
    w_a = av; w_b = bv; w_tmask = mv; w_in_valid = 1;
    @(posedge clk); #1;
    w_in_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (w_out_valid !== 1'b1 || w_p !== ep || w_q !== eq || w_par_ok !== epar) begin
      failures++;
      $display("FAIL %s: got ov=%b p=%h q=%h par=%b exp ov=1 p=%h q=%h par=%b",
               nm, w_out_valid, w_p, w_q, w_par_ok, ep, eq, epar);
    end
  endtask

  task automatic test_wide_and_inverse();
    do_reset();
    // XOR(a)=0 for 4'hA, so total parity is preserved
    run_w(4'hA, {4'h3, 4'h5, 4'hF}, 3'b101, 4'hA, {4'h9, 4'h5, 4'h5}, 1'b1, "wide_a");
    run_w(w_p, w_q, 3'b101, 4'hA, {4'h3, 4'h5, 4'hF}, 1'b1, "wide_a_inverse");
    run_w(4'h1, 12'h000, 3'b001, 4'h1, 12'h001, 1'b0, "wide_b");
    run_w(w_p, w_q, 3'b001, 4'h1, 12'h000, 1'b0, "wide_b_inverse");
    run_w(4'h7, 12'hC3E, 3'b111, 4'h7, 12'hB49, 1'b0, "wide_c");
    run_w(w_p, w_q, 3'b111, 4'h7, 12'hC3E, 1'b0, "wide_c_inverse");
  endtask

  task automatic test_back_to_back();
    int sent, recv, cyc;
    logic ea;
    logic [1:0] eb;
    do_reset();
    sent = 0; recv = 0; cyc = 0;
    while (recv < 10 && cyc < 60) begin
      x_out_ready = (cyc >= 5 && cyc < 8) ? 1'b0 : 1'b1;
      x_in_valid  = (sent < 10);
      x_a = sent[0]; x_b = sent[2:1]; x_tmask = 2'b11;
      #1;
      if (!x_out_ready && x_out_valid) begin
        checks++;
        if (x_in_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_stall_in_ready: cyc=%0d got %b exp 0", cyc, x_in_ready);
        end
      end
      if (x_out_valid && x_out_ready) begin
        ea = recv[0]; eb = recv[2:1];
        checks++;
        if (x_p !== ea || x_q !== {ea ^ eb[1], ea ^ eb[0]}) begin
          failures++;
          $display("FAIL b2b_data%0d: got p=%b q=%b exp p=%b q=%b",
                   recv, x_p, x_q, ea, {ea ^ eb[1], ea ^ eb[0]});
        end
        recv++;
      end
      if (x_in_valid && x_in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    x_in_valid = 0; x_out_ready = 1;
    checks++;
    if (recv != 10) begin
      failures++;
      $display("FAIL b2b_timeout: received %0d exp 10", recv);
    end
    @(posedge clk); #1;
    checks++;
    if (x_cnt !== 16'd10 || x_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_count: got cnt=%0d ov=%b exp cnt=10 ov=0", x_cnt, x_out_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      s_a = k[0]; s_b = k[1:0]; s_tmask = 2'b11; s_in_valid = 1;
      @(posedge clk); #1;
      s_in_valid = 0;
      repeat (2) @(posedge clk);
      #1;
    end
    checks++;
    if (s_cnt !== 3'd7) begin
      failures++;
      $display("FAIL sat_count: got %0d exp 7", s_cnt);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_cnt !== 3'd7) begin
      failures++;
      $display("FAIL sat_hold: got %0d exp 7", s_cnt);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if (s_cnt !== 3'd0) begin
      failures++;
      $display("FAIL sat_reset: got %0d exp 0", s_cnt);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    x_tmask = 2'b11; x_in_valid = 1;
    x_a = 1; x_b = 2'b01;
    @(posedge clk); #1;
    x_a = 0; x_b = 2'b10;
    @(posedge clk); #1;
    x_in_valid = 0;
    checks++;
    if (x_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL inflight_pre: out_valid got %b exp 1", x_out_valid);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if (x_out_valid !== 1'b0 || x_cnt !== 16'd0 || x_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL inflight_reset: got ov=%b cnt=%0d ir=%b exp ov=0 cnt=0 ir=1",
               x_out_valid, x_cnt, x_in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (x_out_valid !== 1'b0 || x_cnt !== 16'd0) begin
        failures++;
        $display("FAIL inflight_discard%0d: got ov=%b cnt=%0d exp ov=0 cnt=0", c, x_out_valid, x_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_wide_and_inverse();
    test_back_to_back();
    test_saturation();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
